// File: rtl/glitcher_pkg.sv
// Shared definitions for the glitcher command path.
// Contents: command opcodes, register indices, response codes,
// the command FSM state type and the opcode -> argument-count helper.
package glitcher_pkg;

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_T = 8'h54;
  localparam logic [7:0] CMD_A = 8'h41;
  localparam logic [7:0] CMD_V = 8'h56;

  localparam logic [7:0] REG_DELAY      = 8'd0;
  localparam logic [7:0] REG_WIDTH      = 8'd1;
  localparam logic [7:0] REG_NUM_PULSES = 8'd2;
  localparam logic [7:0] REG_SPACING    = 8'd3;
  localparam logic [7:0] REG_RESET_LEN  = 8'd4;

  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;
  localparam logic [7:0] RSP_UNK = 8'h3F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARGS,
    ST_EXEC,
    ST_RESP
  } state_e;

  // Number of argument bytes following an opcode; unknown opcodes take none.
  function automatic logic [2:0] arg_count(input logic [7:0] op);
    case (op)
      CMD_W:        arg_count = 3'd4;
      CMD_R:        arg_count = 3'd2;
      CMD_T, CMD_A: arg_count = 3'd1;
      default:      arg_count = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/resp_sender.sv
// Response byte sender: holds up to two reply bytes and pushes them out
// through the UART transmitter handshake.
// Ports:
//   clk, rst        clock, async active-low reset
//   load            one-cycle strobe capturing byte0/byte1/len
//   byte0, byte1    reply bytes, byte0 sent first
//   len             number of bytes to send (1 or 2)
//   tx_busy_i       transmitter busy
//   tx_data_o       byte to transmit, held after each strobe
//   tx_en_o         one-cycle transmit strobe
//   done            one-cycle pulse after the last byte is handed over
module resp_sender
  import glitcher_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] byte0,
  input  logic [7:0] byte1,
  input  logic [1:0] len,
  input  logic       tx_busy_i,
  output logic [7:0] tx_data_o,
  output logic       tx_en_o,
  output logic       done
);

  logic [7:0] head_q;
  logic [7:0] tail_q;
  logic [7:0] last_q;
  logic [1:0] cnt_q;
  logic       holdoff_q;
  logic       done_q;

  // The transmitter raises busy one cycle after accepting a byte, so the
  // cycle right after a strobe is skipped regardless of tx_busy_i.
  assign tx_en_o   = (cnt_q != 2'd0) && !holdoff_q && !tx_busy_i;
  // Present the head byte during the strobe and keep it afterwards so the
  // transmitter sees a stable value until the next strobe.
  assign tx_data_o = tx_en_o ? head_q : last_q;
  assign done      = done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      last_q    <= '0;
      cnt_q     <= '0;
      holdoff_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      holdoff_q <= tx_en_o;
      if (load) begin
        head_q <= byte0;
        tail_q <= byte1;
        cnt_q  <= len;
      end else if (tx_en_o) begin
        last_q <= head_q;
        head_q <= tail_q;
        cnt_q  <= cnt_q - 2'd1;
        done_q <= (cnt_q == 2'd1);
      end
    end
  end

endmodule

// File: rtl/uart_cmd_handler.sv
// Framed UART command decoder driving a per-channel glitch register file.
// Ports:
//   clk, rst            clock, async active-low reset
//   rx_data_i/valid_i   received byte and its one-cycle strobe
//   tx_data_o/en_o      reply byte and its one-cycle strobe
//   tx_busy_i           transmitter busy
//   delay_o, width_o, num_pulses_o, pulse_spacing_o
//                       per-channel settings, channel c in slice c
//   reset_length_o      global target-reset length
//   pulse_en_o, arm_o   per-channel one-cycle fire / arm strobes
//   reset_en_o          one-cycle reset-sequence strobe
//
// state   | meaning
// IDLE    | waiting for an opcode byte
// ARGS    | collecting argument bytes, inter-byte timer running
// EXEC    | one cycle: apply register write / strobes, load reply
// RESP    | reply bytes being sent; incoming bytes dropped
module uart_cmd_handler
  import glitcher_pkg::*;
#(
  parameter int          NUM_CH         = 2,
  parameter int          TIMEOUT_CYCLES = 500000,
  parameter logic [7:0]  VERSION        = 8'h02
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic [7:0]            tx_data_o,
  output logic                  tx_en_o,
  input  logic                  tx_busy_i,
  output logic [16*NUM_CH-1:0]  delay_o,
  output logic [8*NUM_CH-1:0]   width_o,
  output logic [8*NUM_CH-1:0]   num_pulses_o,
  output logic [16*NUM_CH-1:0]  pulse_spacing_o,
  output logic [15:0]           reset_length_o,
  output logic [NUM_CH-1:0]     pulse_en_o,
  output logic                  reset_en_o,
  output logic [NUM_CH-1:0]     arm_o
);

  localparam int             TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]  TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]     CH_MASK  = 8'((1 << NUM_CH) - 1);
  localparam logic [7:0]     NUM_CH_B = 8'(NUM_CH);

  state_e             state_q;
  logic [7:0]         op_q;
  logic [31:0]        args_q;
  logic [2:0]         cnt_q;
  logic [TW-1:0]      tmr_q;
  logic               tmo_q;
  logic               rsp_load_q;
  logic [7:0]         rsp_b0_q;
  logic [7:0]         rsp_b1_q;
  logic [1:0]         rsp_len_q;
  logic               rsp_done;
  logic [NUM_CH-1:0]  pulse_q;
  logic [NUM_CH-1:0]  arm_q;
  logic               reset_en_q;
  logic [15:0]        reset_len_q;

  // Arguments are shifted in MSB first, so the last byte lands in [7:0].
  logic [7:0]  w_ch, w_reg, r_ch, r_reg, mask_m;
  logic [15:0] w_val;
  logic        w_ok, r_ok, wr_go;
  logic [15:0] rd_val;

  assign w_ch   = args_q[31:24];
  assign w_reg  = args_q[23:16];
  assign w_val  = args_q[15:0];
  assign r_ch   = args_q[15:8];
  assign r_reg  = args_q[7:0];
  assign mask_m = args_q[7:0] & CH_MASK;

  always_comb begin
    // reset_length is global, so the channel byte is not checked for it
    w_ok  = (w_reg == REG_RESET_LEN) || ((w_reg < REG_RESET_LEN) && (w_ch < NUM_CH_B));
    r_ok  = (r_reg == REG_RESET_LEN) || ((r_reg < REG_RESET_LEN) && (r_ch < NUM_CH_B));
    wr_go = (state_q == ST_EXEC) && !tmo_q && (op_q == CMD_W) && w_ok;
  end

  always_comb begin
    rd_val = '0;
    if (r_reg == REG_RESET_LEN) begin
      rd_val = reset_len_q;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (r_ch == 8'(c)) begin
          case (r_reg)
            REG_DELAY:      rd_val = delay_o[16*c +: 16];
            REG_WIDTH:      rd_val = {8'h00, width_o[8*c +: 8]};
            REG_NUM_PULSES: rd_val = {8'h00, num_pulses_o[8*c +: 8]};
            REG_SPACING:    rd_val = pulse_spacing_o[16*c +: 16];
            default:        rd_val = '0;
          endcase
        end
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [15:0] delay_q;
    logic [7:0]  width_q;
    logic [7:0]  num_q;
    logic [15:0] spacing_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        delay_q   <= '0;
        width_q   <= '0;
        num_q     <= '0;
        spacing_q <= '0;
      end else if (wr_go && (w_ch == 8'(c))) begin
        case (w_reg)
          REG_DELAY:      delay_q   <= w_val;
          REG_WIDTH:      width_q   <= w_val[7:0];
          REG_NUM_PULSES: num_q     <= w_val[7:0];
          REG_SPACING:    spacing_q <= w_val;
          default:        ;
        endcase
      end
    end

    assign delay_o[16*c +: 16]         = delay_q;
    assign width_o[8*c +: 8]           = width_q;
    assign num_pulses_o[8*c +: 8]      = num_q;
    assign pulse_spacing_o[16*c +: 16] = spacing_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reset_len_q <= '0;
    end else if (wr_go && (w_reg == REG_RESET_LEN)) begin
      reset_len_q <= w_val;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      args_q     <= '0;
      cnt_q      <= '0;
      tmr_q      <= '0;
      tmo_q      <= 1'b0;
      rsp_load_q <= 1'b0;
      rsp_b0_q   <= '0;
      rsp_b1_q   <= '0;
      rsp_len_q  <= '0;
      pulse_q    <= '0;
      arm_q      <= '0;
      reset_en_q <= 1'b0;
    end else begin
      pulse_q    <= '0;
      arm_q      <= '0;
      reset_en_q <= 1'b0;
      rsp_load_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tmo_q <= 1'b0;
          tmr_q <= TMR_LOAD;
          if (rx_valid_i) begin
            op_q   <= rx_data_i;
            args_q <= '0;
            cnt_q  <= arg_count(rx_data_i);
            state_q <= (arg_count(rx_data_i) == 3'd0) ? ST_EXEC : ST_ARGS;
          end
        end
        ST_ARGS: begin
          // A byte arriving on the expiry cycle still counts and reloads.
          if (rx_valid_i) begin
            args_q <= {args_q[23:0], rx_data_i};
            cnt_q  <= cnt_q - 3'd1;
            tmr_q  <= TMR_LOAD;
            if (cnt_q == 3'd1) state_q <= ST_EXEC;
          end else if (tmr_q == '0) begin
            tmo_q   <= 1'b1;
            state_q <= ST_EXEC;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        ST_EXEC: begin
          rsp_load_q <= 1'b1;
          rsp_len_q  <= 2'd1;
          rsp_b1_q   <= '0;
          state_q    <= ST_RESP;
          if (tmo_q) begin
            rsp_b0_q <= RSP_ERR;
          end else begin
            case (op_q)
              CMD_W: rsp_b0_q <= w_ok ? RSP_OK : RSP_ERR;
              CMD_R: begin
                if (r_ok) begin
                  rsp_b0_q  <= rd_val[15:8];
                  rsp_b1_q  <= rd_val[7:0];
                  rsp_len_q <= 2'd2;
                end else begin
                  rsp_b0_q <= RSP_ERR;
                end
              end
              CMD_T: begin
                if (mask_m == 8'h00) begin
                  rsp_b0_q <= RSP_ERR;
                end else begin
                  if (reset_len_q != 16'h0000) reset_en_q <= 1'b1;
                  else pulse_q <= mask_m[NUM_CH-1:0];
                  rsp_b0_q <= RSP_OK;
                end
              end
              CMD_A: begin
                if (mask_m == 8'h00) begin
                  rsp_b0_q <= RSP_ERR;
                end else begin
                  arm_q    <= mask_m[NUM_CH-1:0];
                  rsp_b0_q <= RSP_OK;
                end
              end
              CMD_V: begin
                rsp_b0_q  <= VERSION;
                rsp_b1_q  <= NUM_CH_B;
                rsp_len_q <= 2'd2;
              end
              default: rsp_b0_q <= RSP_UNK;
            endcase
          end
        end
        ST_RESP: begin
          if (rsp_done) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  resp_sender u_resp (
    .clk       (clk),
    .rst       (rst),
    .load      (rsp_load_q),
    .byte0     (rsp_b0_q),
    .byte1     (rsp_b1_q),
    .len       (rsp_len_q),
    .tx_busy_i (tx_busy_i),
    .tx_data_o (tx_data_o),
    .tx_en_o   (tx_en_o),
    .done      (rsp_done)
  );

  assign reset_length_o = reset_len_q;
  assign pulse_en_o     = pulse_q;
  assign arm_o          = arm_q;
  assign reset_en_o     = reset_en_q;

endmodule

// File: tb/tb_uart_cmd_handler.sv
module tb_uart_cmd_handler;

  localparam int         NUM_CH = 2;
  localparam int         TMO    = 40;
  localparam logic [7:0] VER    = 8'h02;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [7:0]            rx_data_i = 8'h00;
  logic                  rx_valid_i = 1'b0;
  logic [7:0]            tx_data_o;
  logic                  tx_en_o;
  logic                  tx_busy_i = 1'b0;
  logic [16*NUM_CH-1:0]  delay_o;
  logic [8*NUM_CH-1:0]   width_o;
  logic [8*NUM_CH-1:0]   num_pulses_o;
  logic [16*NUM_CH-1:0]  pulse_spacing_o;
  logic [15:0]           reset_length_o;
  logic [NUM_CH-1:0]     pulse_en_o;
  logic                  reset_en_o;
  logic [NUM_CH-1:0]     arm_o;

  always #5 clk = ~clk;

  uart_cmd_handler #(.NUM_CH(NUM_CH), .TIMEOUT_CYCLES(TMO), .VERSION(VER)) dut (
    .clk(clk), .rst(rst), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .tx_data_o(tx_data_o), .tx_en_o(tx_en_o), .tx_busy_i(tx_busy_i),
    .delay_o(delay_o), .width_o(width_o), .num_pulses_o(num_pulses_o),
    .pulse_spacing_o(pulse_spacing_o), .reset_length_o(reset_length_o),
    .pulse_en_o(pulse_en_o), .reset_en_o(reset_en_o), .arm_o(arm_o)
  );

  int tests = 0;
  int failed = 0;

  // transmitter / strobe observation
  logic [7:0]        rx_q[$];
  int                busy_left = 0;
  bit                busy_start = 0;
  bit                force_busy = 0;
  int                pulse_cyc, arm_cyc, rst_cyc;
  logic [NUM_CH-1:0] pulse_or, arm_or;

  always @(negedge clk) begin
    if (tx_en_o) begin
      rx_q.push_back(tx_data_o);
      busy_start = 1;
      tests++;
      if (tx_busy_i !== 1'b0) begin
        failed++;
        $display("FAIL tx_en_while_busy: busy=%b required 0", tx_busy_i);
      end
    end
    if (pulse_en_o != '0) begin pulse_cyc++; pulse_or |= pulse_en_o; end
    if (arm_o != '0) begin arm_cyc++; arm_or |= arm_o; end
    if (reset_en_o) rst_cyc++;
  end

  // busy rises the cycle after an accepted byte and lasts three cycles
  always @(posedge clk) begin
    #1;
    if (busy_left > 0) busy_left--;
    if (busy_start) begin busy_left = 3; busy_start = 0; end
    tx_busy_i = force_busy || (busy_left > 0);
  end

  // reference model
  logic [15:0]       m_delay[NUM_CH];
  logic [15:0]       m_spacing[NUM_CH];
  logic [7:0]        m_width[NUM_CH];
  logic [7:0]        m_num[NUM_CH];
  logic [15:0]       m_rlen;
  logic [7:0]        exp_rsp[$];
  logic [NUM_CH-1:0] exp_pulse, exp_arm;
  bit                exp_rst;

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_delay[i] = '0; m_spacing[i] = '0; m_width[i] = '0; m_num[i] = '0;
    end
    m_rlen = '0;
  endtask

  task automatic model_cmd(input logic [7:0] c[$]);
    logic [7:0]  ch, rg, m;
    logic [15:0] v;
    exp_rsp.delete();
    exp_pulse = '0; exp_arm = '0; exp_rst = 0;
    case (c[0])
      8'h57: begin
        ch = c[1]; rg = c[2]; v = {c[3], c[4]};
        if (rg > 4 || (rg < 4 && ch >= NUM_CH)) exp_rsp.push_back(8'h45);
        else begin
          case (rg)
            0: m_delay[ch] = v;
            1: m_width[ch] = v[7:0];
            2: m_num[ch] = v[7:0];
            3: m_spacing[ch] = v;
            default: m_rlen = v;
          endcase
          exp_rsp.push_back(8'h4B);
        end
      end
      8'h52: begin
        ch = c[1]; rg = c[2]; v = '0;
        if (rg > 4 || (rg < 4 && ch >= NUM_CH)) exp_rsp.push_back(8'h45);
        else begin
          case (rg)
            0: v = m_delay[ch];
            1: v = {8'h00, m_width[ch]};
            2: v = {8'h00, m_num[ch]};
            3: v = m_spacing[ch];
            default: v = m_rlen;
          endcase
          exp_rsp.push_back(v[15:8]);
          exp_rsp.push_back(v[7:0]);
        end
      end
      8'h54, 8'h41: begin
        m = c[1] & 8'((1 << NUM_CH) - 1);
        if (m == 0) exp_rsp.push_back(8'h45);
        else begin
          if (c[0] == 8'h41) exp_arm = m[NUM_CH-1:0];
          else if (m_rlen != 0) exp_rst = 1;
          else exp_pulse = m[NUM_CH-1:0];
          exp_rsp.push_back(8'h4B);
        end
      end
      8'h56: begin exp_rsp.push_back(VER); exp_rsp.push_back(8'(NUM_CH)); end
      default: exp_rsp.push_back(8'h3F);
    endcase
  endtask

  // stimulus helpers (called at a falling edge, return at a falling edge)
  task automatic drive_byte(input logic [7:0] b);
    rx_data_i = b;
    rx_valid_i = 1'b1;
    @(negedge clk);
    rx_valid_i = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] c[$], input int gap);
    for (int i = 0; i < c.size(); i++) begin
      drive_byte(c[i]);
      if (i < c.size() - 1) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic wait_resp(input int n);
    for (int i = 0; i < 3000 && rx_q.size() < n; i++) @(negedge clk);
  endtask

  task automatic clear_mon();
    rx_q.delete();
    pulse_cyc = 0; arm_cyc = 0; rst_cyc = 0;
    pulse_or = '0; arm_or = '0;
  endtask

  // ---------------------------------------------------------------
  task automatic test_reset();
    tests++;
    if ({delay_o, width_o, num_pulses_o, pulse_spacing_o, reset_length_o} !== '0) begin
      failed++; $display("FAIL reset_regs: got nonzero register outputs, required 0");
    end
    tests++;
    if ({pulse_en_o, reset_en_o, arm_o, tx_en_o} !== '0) begin
      failed++; $display("FAIL reset_strobes: got %b required 0", {pulse_en_o, reset_en_o, arm_o, tx_en_o});
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({delay_o, width_o, num_pulses_o, pulse_spacing_o, reset_length_o, pulse_en_o, arm_o} !== '0) begin
      failed++; $display("FAIL reset_after_release: outputs nonzero, required 0");
    end
  endtask

  task automatic test_version();
    logic [7:0] c[$];
    c = {8'h56};
    clear_mon(); model_cmd(c); send_cmd(c, 0);
    wait_resp(2); repeat (6) @(negedge clk);
    tests++;
    if (rx_q.size() != 2) begin
      failed++; $display("FAIL version_len: got %0d bytes required 2", rx_q.size());
    end else begin
      tests++;
      if (rx_q[0] !== 8'h02 || rx_q[1] !== 8'h02) begin
        failed++; $display("FAIL version_bytes: got %h %h required 02 02", rx_q[0], rx_q[1]);
      end
    end
  endtask

  task automatic test_write_read();
    logic [7:0] c[$];
    c = {8'h57, 8'h01, 8'h00, 8'h12, 8'h34};
    clear_mon(); model_cmd(c); send_cmd(c, 1);
    tests++;
    if (delay_o[31:16] !== 16'h0000) begin
      failed++; $display("FAIL write_early: delay1=%h required 0000 in exec cycle", delay_o[31:16]);
    end
    @(negedge clk);
    tests++;
    if (delay_o[31:16] !== 16'h1234) begin
      failed++; $display("FAIL write_n2: delay1=%h required 1234", delay_o[31:16]);
    end
    tests++;
    if (delay_o[15:0] !== m_delay[0]) begin
      failed++; $display("FAIL write_ch0: delay0=%h required %h", delay_o[15:0], m_delay[0]);
    end
    wait_resp(1); repeat (6) @(negedge clk);
    tests++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h4B) begin
      failed++; $display("FAIL write_ack: got %0d bytes first %h required 1 byte 4b", rx_q.size(), rx_q.size() ? rx_q[0] : 8'h00);
    end
    c = {8'h52, 8'h01, 8'h00};
    clear_mon(); model_cmd(c); send_cmd(c, 0);
    wait_resp(2); repeat (6) @(negedge clk);
    tests++;
    if (rx_q.size() != 2 || rx_q[0] !== 8'h12 || rx_q[1] !== 8'h34) begin
      failed++; $display("FAIL read_back: got %0d bytes required 12 34", rx_q.size());
    end
  endtask

  task automatic test_errors();
    logic [7:0] c[$];
    logic [63:0] snap;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) c = {8'h57, 8'h05, 8'h00, 8'h00, 8'h01};
      else        c = {8'h57, 8'h00, 8'h07, 8'h00, 8'h01};
      snap = {delay_o, width_o, num_pulses_o};
      clear_mon(); model_cmd(c); send_cmd(c, 0);
      wait_resp(1); repeat (6) @(negedge clk);
      tests++;
      if (rx_q.size() != 1 || rx_q[0] !== 8'h45) begin
        failed++; $display("FAIL err_reply%0d: got %0d bytes first %h required 45", k, rx_q.size(), rx_q.size() ? rx_q[0] : 8'h00);
      end
      tests++;
      if ({delay_o, width_o, num_pulses_o} !== snap || pulse_spacing_o !== '0 || reset_length_o !== m_rlen) begin
        failed++; $display("FAIL err_nochange%0d: registers changed on error", k);
      end
    end
  endtask

  task automatic test_trigger();
    logic [7:0] c[$];
    c = {8'h54, 8'hFF};
    clear_mon(); model_cmd(c); send_cmd(c, 0);
    @(negedge clk);
    tests++;
    if (pulse_en_o !== 2'b11) begin
      failed++; $display("FAIL trig_pulse: pulse_en=%b required 11", pulse_en_o);
    end
    @(negedge clk);
    tests++;
    if (pulse_en_o !== 2'b00) begin
      failed++; $display("FAIL trig_one_cycle: pulse_en=%b required 00", pulse_en_o);
    end
    wait_resp(1); repeat (6) @(negedge clk);
    tests++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h4B || pulse_cyc != 1 || rst_cyc != 0) begin
      failed++; $display("FAIL trig_summary: bytes=%0d pulse_cyc=%0d rst_cyc=%0d required 1 1 0", rx_q.size(), pulse_cyc, rst_cyc);
    end
    c = {8'h57, 8'h00, 8'h04, 8'h00, 8'h10};
    clear_mon(); model_cmd(c); send_cmd(c, 0);
    wait_resp(1); repeat (6) @(negedge clk);
    tests++;
    if (reset_length_o !== 16'h0010) begin
      failed++; $display("FAIL rlen_write: reset_length=%h required 0010", reset_length_o);
    end
    c = {8'h54, 8'h01};
    clear_mon(); model_cmd(c); send_cmd(c, 0);
    wait_resp(1); repeat (6) @(negedge clk);
    tests++;
    if (rst_cyc != 1 || pulse_cyc != 0 || rx_q.size() != 1 || rx_q[0] !== 8'h4B) begin
      failed++; $display("FAIL trig_reset: rst_cyc=%0d pulse_cyc=%0d bytes=%0d required 1 0 1", rst_cyc, pulse_cyc, rx_q.size());
    end
    c = {8'h54, 8'hFC};
    clear_mon(); model_cmd(c); send_cmd(c, 0);
    wait_resp(1); repeat (6) @(negedge clk);
    tests++;
    if (rst_cyc != 0 || pulse_cyc != 0 || rx_q.size() != 1 || rx_q[0] !== 8'h45) begin
      failed++; $display("FAIL trig_masked_zero: rst_cyc=%0d pulse_cyc=%0d bytes=%0d required 0 0 1 (45)", rst_cyc, pulse_cyc, rx_q.size());
    end
    c = {8'h57, 8'h00, 8'h04, 8'h00, 8'h00};
    clear_mon(); model_cmd(c); send_cmd(c, 0);
    wait_resp(1); repeat (6) @(negedge clk);
  endtask

  task automatic test_timeout();
    logic [7:0] c[$];
    int waited;
    clear_mon();
    exp_rsp.delete();
    drive_byte(8'h57);
    drive_byte(8'h00);
    repeat (TMO - 4) @(negedge clk);
    tests++;
    if (rx_q.size() != 0) begin
      failed++; $display("FAIL timeout_early: got %0d bytes before %0d idle cycles, required 0", rx_q.size(), TMO);
    end
    waited = 0;
    while (rx_q.size() < 1 && waited < 12) begin @(negedge clk); waited++; end
    tests++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h45) begin
      failed++; $display("FAIL timeout_reply: got %0d bytes required one 45 within 12 cycles", rx_q.size());
    end
    repeat (TMO + 10) @(negedge clk);
    tests++;
    if (rx_q.size() != 1 || {delay_o, width_o, num_pulses_o, pulse_spacing_o} !==
        {m_delay[1], m_delay[0], m_width[1], m_width[0], m_num[1], m_num[0], m_spacing[1], m_spacing[0]}) begin
      failed++; $display("FAIL timeout_once: bytes=%0d required 1, registers unchanged", rx_q.size());
    end
    c = {8'h41, 8'h02};
    clear_mon(); model_cmd(c); send_cmd(c, 0);
    wait_resp(1); repeat (6) @(negedge clk);
    tests++;
    if (arm_or !== 2'b10 || arm_cyc != 1 || rx_q.size() != 1 || rx_q[0] !== 8'h4B) begin
      failed++; $display("FAIL arm_after_timeout: arm=%b cyc=%0d bytes=%0d required 10 1 1", arm_or, arm_cyc, rx_q.size());
    end
  endtask

  task automatic test_busy();
    logic [7:0] c[$];
    c = {8'h56};
    clear_mon();
    force_busy = 1;
    repeat (2) @(negedge clk);
    send_cmd(c, 0);
    repeat (100) @(negedge clk);
    tests++;
    if (rx_q.size() != 0) begin
      failed++; $display("FAIL busy_hold: got %0d bytes while busy, required 0", rx_q.size());
    end
    force_busy = 0;
    wait_resp(2); repeat (6) @(negedge clk);
    tests++;
    if (rx_q.size() != 2 || rx_q[0] !== VER || rx_q[1] !== 8'(NUM_CH)) begin
      failed++; $display("FAIL busy_release: got %0d bytes required 02 02 in order", rx_q.size());
    end
  endtask

  task automatic test_random();
    logic [7:0]  c[$];
    logic [7:0]  op, ch, rg;
    logic [15:0] v;
    logic [16*NUM_CH-1:0] e_delay, e_spacing;
    logic [8*NUM_CH-1:0]  e_width, e_num;
    int sel;
    for (int it = 0; it < 60; it++) begin
      sel = $urandom_range(0, 5);
      ch = 8'($urandom_range(0, NUM_CH));
      rg = 8'($urandom_range(0, 5));
      if (rg == 4) ch = 8'($urandom_range(0, NUM_CH - 1));
      v = 16'($urandom);
      case (sel)
        0: c = {8'h57, ch, rg, v[15:8], v[7:0]};
        1: c = {8'h52, ch, rg};
        2: c = {8'h54, v[7:0]};
        3: c = {8'h41, v[7:0]};
        4: c = {8'h56};
        default: begin
          op = 8'($urandom);
          while (op == 8'h57 || op == 8'h52 || op == 8'h54 || op == 8'h41 || op == 8'h56) op = 8'($urandom);
          c = {op};
        end
      endcase
      clear_mon(); model_cmd(c); send_cmd(c, $urandom_range(0, 3));
      wait_resp(exp_rsp.size()); repeat (5) @(negedge clk);
      tests++;
      if (rx_q.size() != exp_rsp.size()) begin
        failed++; $display("FAIL rand%0d_len: op=%h got %0d bytes required %0d", it, c[0], rx_q.size(), exp_rsp.size());
      end else begin
        for (int b = 0; b < exp_rsp.size(); b++) begin
          tests++;
          if (rx_q[b] !== exp_rsp[b]) begin
            failed++; $display("FAIL rand%0d_byte%0d: op=%h got %h required %h", it, b, c[0], rx_q[b], exp_rsp[b]);
          end
        end
      end
      for (int k = 0; k < NUM_CH; k++) begin
        e_delay[16*k +: 16] = m_delay[k]; e_spacing[16*k +: 16] = m_spacing[k];
        e_width[8*k +: 8] = m_width[k];   e_num[8*k +: 8] = m_num[k];
      end
      tests++;
      if (delay_o !== e_delay || width_o !== e_width || num_pulses_o !== e_num ||
          pulse_spacing_o !== e_spacing || reset_length_o !== m_rlen) begin
        failed++; $display("FAIL rand%0d_regs: delay=%h width=%h num=%h spacing=%h rlen=%h required %h %h %h %h %h",
                           it, delay_o, width_o, num_pulses_o, pulse_spacing_o, reset_length_o,
                           e_delay, e_width, e_num, e_spacing, m_rlen);
      end
      tests++;
      if (pulse_or !== exp_pulse || pulse_cyc != int'(exp_pulse != 0) || arm_or !== exp_arm ||
          arm_cyc != int'(exp_arm != 0) || rst_cyc != int'(exp_rst)) begin
        failed++; $display("FAIL rand%0d_strobes: pulse=%b/%0d arm=%b/%0d rst=%0d required %b %b %0d",
                           it, pulse_or, pulse_cyc, arm_or, arm_cyc, rst_cyc, exp_pulse, exp_arm, exp_rst);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] c[$];
    c = {8'h57, 8'h01, 8'h00, 8'hAB, 8'hCD};
    model_cmd(c); send_cmd(c, 0);
    wait_resp(1); repeat (6) @(negedge clk);
    clear_mon();
    drive_byte(8'h57); drive_byte(8'h00); drive_byte(8'h00);
    rst = 1'b0;
    busy_left = 0; busy_start = 0;
    @(negedge clk);
    tests++;
    if ({delay_o, width_o, num_pulses_o, pulse_spacing_o, reset_length_o} !== '0) begin
      failed++; $display("FAIL reset_mid_regs: delay=%h required 0", delay_o);
    end
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    c = {8'h52, 8'h01, 8'h00};
    clear_mon(); model_cmd(c); send_cmd(c, 0);
    wait_resp(2); repeat (6) @(negedge clk);
    tests++;
    if (rx_q.size() != 2 || rx_q[0] !== 8'h00 || rx_q[1] !== 8'h00) begin
      failed++; $display("FAIL reset_mid_idle: got %0d bytes required 00 00", rx_q.size());
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    test_reset();
    test_version();
    test_write_read();
    test_errors();
    test_trigger();
    test_timeout();
    test_busy();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
    $fatal(1, "watchdog");
  end

endmodule
